// File: rtl/spi_mem_master.sv
// SPI master sequencer: turns parallel read/write requests into 16-bit frames
// (addr[6:0], rw, data[7:0]) for the lab SPI memory. Macro SPI_MEM_MASTER_VERIFY_EN adds write read-back.
module spi_mem_master #(
   parameter int CLK_DIV    = 4,
   parameter int GAP_HALVES = 2
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic       req_rw,
   input  logic [6:0] req_addr,
   input  logic [7:0] req_wdata,
   output logic       rsp_valid,
   output logic [7:0] rsp_rdata,
   output logic       rsp_err,
   output logic       busy,
   output logic       cs,
   output logic       sck,
   output logic       mosi,
   input  logic       miso
);

   typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

   localparam logic [7:0]  DIV_LAST = 8'(CLK_DIV - 1);
   localparam logic [15:0] GAP_LAST = 16'(GAP_HALVES - 1);

   state_t      state_reg, state_next;
   logic [7:0]  cnt_reg, cnt_next;
   logic [3:0]  bit_reg, bit_next;
   logic [15:0] gap_reg, gap_next;
   logic [15:0] tx_reg, tx_next;
   logic [7:0]  rx_reg, rx_next;
   logic        rw_reg, rw_next;
   logic        cs_reg, cs_next;
   logic        sck_reg, sck_next;
   logic        rsp_valid_reg, rsp_valid_next;
   logic [7:0]  rsp_rdata_reg, rsp_rdata_next;
   logic        half_end;
   logic [7:0]  cnt_dec;
`ifdef SPI_MEM_MASTER_VERIFY_EN
   logic [6:0]  addr_reg, addr_next;
   logic [7:0]  wdata_reg, wdata_next;
   logic        verify_reg, verify_next;
   logic        err_reg, err_next;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg     <= IDLE;
         cnt_reg       <= '0;
         bit_reg       <= '0;
         gap_reg       <= '0;
         tx_reg        <= '0;
         rx_reg        <= '0;
         rw_reg        <= 1'b0;
         cs_reg        <= 1'b1;
         sck_reg       <= 1'b0;
         rsp_valid_reg <= 1'b0;
         rsp_rdata_reg <= '0;
`ifdef SPI_MEM_MASTER_VERIFY_EN
         addr_reg      <= '0;
         wdata_reg     <= '0;
         verify_reg    <= 1'b0;
         err_reg       <= 1'b0;
`endif
      end else begin
         state_reg     <= state_next;
         cnt_reg       <= cnt_next;
         bit_reg       <= bit_next;
         gap_reg       <= gap_next;
         tx_reg        <= tx_next;
         rx_reg        <= rx_next;
         rw_reg        <= rw_next;
         cs_reg        <= cs_next;
         sck_reg       <= sck_next;
         rsp_valid_reg <= rsp_valid_next;
         rsp_rdata_reg <= rsp_rdata_next;
`ifdef SPI_MEM_MASTER_VERIFY_EN
         addr_reg      <= addr_next;
         wdata_reg     <= wdata_next;
         verify_reg    <= verify_next;
         err_reg       <= err_next;
`endif
      end
   end

   always_comb begin
      state_next     = state_reg;
      cnt_next       = cnt_reg;
      bit_next       = bit_reg;
      gap_next       = gap_reg;
      tx_next        = tx_reg;
      rx_next        = rx_reg;
      rw_next        = rw_reg;
      cs_next        = cs_reg;
      sck_next       = sck_reg;
      rsp_valid_next = 1'b0;
      rsp_rdata_next = rsp_rdata_reg;
`ifdef SPI_MEM_MASTER_VERIFY_EN
      addr_next      = addr_reg;
      wdata_next     = wdata_reg;
      verify_next    = verify_reg;
      err_next       = err_reg;
`endif
      half_end = (cnt_reg == 8'd0);
      cnt_dec  = half_end ? DIV_LAST : cnt_reg - 8'd1;

      case (state_reg)
         IDLE: begin
            cnt_next = DIV_LAST;
            if (req_valid) begin
               state_next = SETUP;
               rw_next    = req_rw;
               tx_next    = {req_addr, req_rw, (req_rw ? 8'h00 : req_wdata)};
               cs_next    = 1'b0;
               bit_next   = '0;
               gap_next   = '0;
`ifdef SPI_MEM_MASTER_VERIFY_EN
               addr_next  = req_addr;
               wdata_next = req_wdata;
`endif
            end
         end
         SETUP: begin
            cnt_next = cnt_dec;
            if (half_end) begin
               state_next = SHIFT;
               sck_next   = 1'b1;
            end
         end
         SHIFT: begin
            cnt_next = cnt_dec;
            if (half_end) begin
               if (sck_reg) begin
                  // Falling edge: next bit onto mosi, read data sampled MSB first.
                  sck_next = 1'b0;
                  tx_next  = {tx_reg[14:0], 1'b0};
                  if (rw_reg && bit_reg[3])
                     rx_next = {rx_reg[6:0], miso};
               end else if (bit_reg == 4'd15) begin
                  state_next = HOLD;
               end else begin
                  bit_next = bit_reg + 4'd1;
                  sck_next = 1'b1;
               end
            end
         end
         HOLD: begin
            cnt_next = cnt_dec;
            if (half_end) begin
               state_next = GAP;
               cs_next    = 1'b1;
               gap_next   = '0;
`ifdef SPI_MEM_MASTER_VERIFY_EN
               if (!rw_reg) begin
                  verify_next = 1'b1;
               end else begin
                  rsp_valid_next = 1'b1;
                  rsp_rdata_next = rx_reg;
                  err_next       = verify_reg && (rx_reg != wdata_reg);
                  verify_next    = 1'b0;
               end
`else
               rsp_valid_next = 1'b1;
               if (rw_reg)
                  rsp_rdata_next = rx_reg;
`endif
            end
         end
         GAP: begin
            cnt_next = cnt_dec;
            if (half_end)
               gap_next = gap_reg + 16'd1;
            // Leaving one cycle early lets the IDLE accept cycle complete the cs-high gap.
`ifdef SPI_MEM_MASTER_VERIFY_EN
            if (verify_reg) begin
               if (gap_reg == GAP_LAST && half_end) begin
                  state_next = SETUP;
                  rw_next    = 1'b1;
                  tx_next    = {addr_reg, 1'b1, 8'h00};
                  cs_next    = 1'b0;
                  bit_next   = '0;
                  gap_next   = '0;
                  cnt_next   = DIV_LAST;
               end
            end else if (gap_reg == GAP_LAST && cnt_reg == 8'd1) begin
               state_next = IDLE;
            end
`else
            if (gap_reg == GAP_LAST && cnt_reg == 8'd1)
               state_next = IDLE;
`endif
         end
         default: state_next = IDLE;
      endcase
   end

   assign req_ready = (state_reg == IDLE);
   assign busy      = !req_ready;
   assign cs        = cs_reg;
   assign sck       = sck_reg;
   assign mosi      = tx_reg[15];
   assign rsp_valid = rsp_valid_reg;
   assign rsp_rdata = rsp_rdata_reg;
`ifdef SPI_MEM_MASTER_VERIFY_EN
   assign rsp_err   = err_reg;
`else
   assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_spi_mem_master.sv
// Directed bench for spi_mem_master: slave-side frame monitor plus a miso byte model.
// Build with SPI_MEM_MASTER_VERIFY_EN to exercise the write read-back path.
module tb_spi_mem_master;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       req_valid = 1'b0;
   logic       req_rw = 1'b0;
   logic [6:0] req_addr = '0;
   logic [7:0] req_wdata = '0;
   logic       miso = 1'b0;
   logic       req_ready, rsp_valid, rsp_err, busy, cs, sck, mosi;
   logic [7:0] rsp_rdata;

   always #5 clk = ~clk;

   spi_mem_master #(.CLK_DIV(4), .GAP_HALVES(2)) dut (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .busy(busy), .cs(cs), .sck(sck), .mosi(mosi), .miso(miso)
   );

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [7:0]  miso_byte = 8'h00;
   logic [15:0] sh_bits = '0;
   int          sh_rises = 0;
   logic        cs_prev = 1'b1;
   int          low_cnt = 0, high_cnt = 0, n_starts = 0, rsp_cnt = 0;
   logic [7:0]  rsp_last_rdata = '0;
   logic        rsp_last_err = 1'b0;
   logic [15:0] fbits_q[$];
   int          flow_q[$], frises_q[$], fgap_q[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Slave model: samples mosi on sck rise, drives the read byte during bits 8..15.
   always @(posedge sck or negedge cs) begin
      if (!sck) begin
         sh_bits  = '0;
         sh_rises = 0;
         miso     = 1'b0;
      end else if (!cs) begin
         sh_bits = {sh_bits[14:0], mosi};
         if (sh_rises >= 8) miso = miso_byte[15 - sh_rises];
         else               miso = 1'b0;
         sh_rises++;
      end
   end

   always @(negedge clk) begin
      if (!reset_n) begin
         low_cnt  = 0;
         high_cnt = 0;
      end else begin
         if (!cs && cs_prev) begin
            fgap_q.push_back(high_cnt);
            low_cnt = 0;
            n_starts++;
         end
         if (cs && !cs_prev) begin
            flow_q.push_back(low_cnt);
            fbits_q.push_back(sh_bits);
            frises_q.push_back(sh_rises);
            high_cnt = 0;
         end
         if (!cs) low_cnt++;
         else     high_cnt++;
         if (rsp_valid) begin
            rsp_cnt++;
            rsp_last_rdata = rsp_rdata;
            rsp_last_err   = rsp_err;
         end
      end
      cs_prev = cs;
   end

   task automatic do_req(input logic rw, input logic [6:0] a, input logic [7:0] d);
      int i;
      i = 0;
      @(negedge clk);
      while (!req_ready && i < 2000) begin
         @(negedge clk);
         i++;
      end
      check("ready_before_req", 32'(req_ready), 32'd1);
      req_valid = 1'b1;
      req_rw    = rw;
      req_addr  = a;
      req_wdata = d;
      @(negedge clk);
      req_valid = 1'b0;
      $display("txn req rw=%0d addr=0x%02h wdata=0x%02h", rw, a, d);
   endtask

   task automatic wait_rsp(input int target);
      for (int i = 0; i < 3000 && rsp_cnt < target; i++) @(negedge clk);
      check("rsp_count", 32'(rsp_cnt), 32'(target));
      for (int i = 0; i < 3000 && !req_ready; i++) @(negedge clk);
      $display("txn rsp rdata=0x%02h err=%0d", rsp_last_rdata, rsp_last_err);
   endtask

   initial begin
      int b, r, s;
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int b, r, s;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      check("rst_cs", 32'(cs), 32'd1);
      check("rst_sck", 32'(sck), 32'd0);
      check("rst_mosi", 32'(mosi), 32'd0);
      check("rst_ready", 32'(req_ready), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rdata", 32'(rsp_rdata), 32'h00);
      check("rst_err", 32'(rsp_err), 32'd0);

      // Read 0x05, slave returns 0x9E
      b = fbits_q.size(); r = rsp_cnt;
      miso_byte = 8'h9E;
      do_req(1'b1, 7'h05, 8'h00);
      wait_rsp(r + 1);
      check("rd_bits", 32'(fbits_q[b]), 32'h0B00);
      check("rd_rises", 32'(frises_q[b]), 32'd16);
      check("rd_rdata", 32'(rsp_last_rdata), 32'h9E);
      check("rd_err", 32'(rsp_last_err), 32'd0);

`ifndef SPI_MEM_MASTER_VERIFY_EN
      // Write 0x2A <- 0xC5; read data must hold 0x9E
      b = fbits_q.size(); r = rsp_cnt;
      miso_byte = 8'hFF;
      do_req(1'b0, 7'h2A, 8'hC5);
      repeat (20) @(negedge clk);
      check("wr_busy", 32'(busy), 32'd1);
      check("wr_ready", 32'(req_ready), 32'd0);
      wait_rsp(r + 1);
      check("wr_bits", 32'(fbits_q[b]), 32'h54C5);
      check("wr_rises", 32'(frises_q[b]), 32'd16);
      check("wr_cs_low", 32'(flow_q[b]), 32'd136);
      check("wr_rdata_hold", 32'(rsp_rdata), 32'h9E);
      check("wr_err", 32'(rsp_last_err), 32'd0);

      // Back-to-back writes with req_valid held
      b = fbits_q.size(); r = rsp_cnt; s = n_starts;
      @(negedge clk);
      req_valid = 1'b1; req_rw = 1'b0; req_addr = 7'h11; req_wdata = 8'h33;
      @(negedge clk);
      req_addr = 7'h12; req_wdata = 8'h44;
      for (int i = 0; i < 1000 && n_starts < s + 2; i++) @(negedge clk);
      req_valid = 1'b0;
      $display("txn b2b addr=0x11/0x12 wdata=0x33/0x44");
      wait_rsp(r + 2);
      check("b2b_bits0", 32'(fbits_q[b]), 32'h2233);
      check("b2b_low0", 32'(flow_q[b]), 32'd136);
      check("b2b_bits1", 32'(fbits_q[b + 1]), 32'h2444);
      check("b2b_gap", 32'(fgap_q[s + 1]), 32'd8);

      // New request presented mid-frame must be ignored
      b = fbits_q.size(); r = rsp_cnt; s = n_starts;
      do_req(1'b0, 7'h40, 8'h5A);
      repeat (30) @(negedge clk);
      req_valid = 1'b1; req_rw = 1'b0; req_addr = 7'h7F; req_wdata = 8'hFF;
      @(negedge clk);
      check("mid_ready", 32'(req_ready), 32'd0);
      repeat (20) @(negedge clk);
      req_valid = 1'b0;
      wait_rsp(r + 1);
      repeat (50) @(negedge clk);
      check("mid_starts", 32'(n_starts), 32'(s + 1));
      check("mid_bits", 32'(fbits_q[b]), 32'h805A);
`else
      // Write 0x11 to 0x03 with read-back returning 0x10
      b = fbits_q.size(); r = rsp_cnt;
      miso_byte = 8'h10;
      do_req(1'b0, 7'h03, 8'h11);
      for (int i = 0; i < 1000 && flow_q.size() < b + 1; i++) @(negedge clk);
      check("vfy_busy_gap", 32'(busy), 32'd1);
      wait_rsp(r + 1);
      repeat (20) @(negedge clk);
      check("vfy_single_rsp", 32'(rsp_cnt), 32'(r + 1));
      check("vfy_bits_wr", 32'(fbits_q[b]), 32'h0611);
      check("vfy_bits_rd", 32'(fbits_q[b + 1]), 32'h0700);
      check("vfy_rdata", 32'(rsp_last_rdata), 32'h10);
      check("vfy_err", 32'(rsp_last_err), 32'd1);
`endif

      // Reset while sck is high during bit 5
      r = rsp_cnt;
      do_req(1'b0, 7'h55, 8'hAA);
      for (int i = 0; i < 500 && sh_rises < 6; i++) @(negedge clk);
      check("rst_mid_rises", 32'(sh_rises), 32'd6);
      reset_n = 1'b0;
      #1;
      check("rst_mid_cs", 32'(cs), 32'd1);
      check("rst_mid_sck", 32'(sck), 32'd0);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (300) @(negedge clk);
      $display("txn reset mid-frame released");
      check("rst_mid_no_rsp", 32'(rsp_cnt), 32'(r));
      check("rst_mid_ready", 32'(req_ready), 32'd1);
      check("rst_mid_busy", 32'(busy), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/spi_mem_master.md
Name: spi_mem_master

Overview:
- SPI master sequencer that drives the lab SPI memory slave (cs/sck/mosi/miso) from a local parallel request port.
- Serialises each request into one 16-bit frame: 7-bit address, R/W bit, 8 data bits. For reads, it captures the returned byte.
- Sits between the host-side test logic and the SPI memory; it is the only driver of cs, sck and mosi.

Parameters:
- CLK_DIV, 4, clk cycles per sck half-period; legal range 2..255.
- GAP_HALVES, 2, sck half-periods cs stays high between frames; minimum 1.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_rw  in  1  1 = read, 0 = write
- req_addr  in  7  memory address
- req_wdata  in  8  write data
- rsp_valid  out  1  one-cycle pulse at transaction completion
- rsp_rdata  out  8  read data; valid when rsp_valid pulses after a read
- rsp_err  out  1  verify mismatch flag (optional feature)
- busy  out  1  high from request accept until req_ready returns
- cs  out  1  SPI chip select, active low
- sck  out  1  SPI clock, idles low
- mosi  out  1  SPI data to slave
- miso  in  1  SPI data from slave

Behaviour:
- Reset (async assert, sync release): state IDLE, cs=1, sck=0, mosi=0, req_ready=1, busy=0, rsp_valid=0, rsp_rdata=0x00, rsp_err=0, counters cleared.
- Reset mid-frame: cs rises and sck drops immediately. The aborted transaction produces no response.
- Accept rule: a request is accepted on a clk edge with req_valid & req_ready. req_rw, req_addr and req_wdata are registered at that edge. Later changes to the inputs are ignored. req_ready=0 in every state except IDLE.
- Frame bit order, MSB first: addr[6:0], then rw, then data[7:0]. Data bits carry wdata for a write and don't-care (0) for a read.
- States:
  - IDLE: waits for accept, then goes to SETUP.
  - SETUP: cs=0, mosi=bit0. Lasts CLK_DIV cycles, then goes to SHIFT.
  - SHIFT: 16 bit periods of 2*CLK_DIV cycles each. sck is high for the first half and low for the second. mosi changes only on the cycle sck falls, presenting the next bit. On the falling cycle of bits 8..15 of a read, miso is shifted into rdata MSB first. After the 16th falling edge, goes to HOLD.
  - HOLD: cs stays 0 and sck stays 0 for CLK_DIV cycles, then goes to GAP.
  - GAP: cs=1, mosi=0 for GAP_HALVES*CLK_DIV cycles, then goes to IDLE.
- rsp_valid pulses exactly one cycle, on the first GAP cycle (the same cycle cs returns high).
  - Read: rsp_rdata updates in that same cycle.
  - Write: rsp_rdata holds its previous value.
- busy = !req_ready.
- Frame length: cs low for CLK_DIV*(2+32) cycles. Exactly 16 sck rising edges per frame.
- Half-period counter is 8 bits and reloads on every half-period boundary. Bit counter is 4 bits and saturates: no wrap into a 17th bit.
- req_valid held continuously: the next request is accepted on the first IDLE cycle, so cs high time is exactly GAP_HALVES*CLK_DIV cycles.

Optional Feature:
- Macro: SPI_MEM_MASTER_VERIFY_EN.
- Defined:
  - Each write is followed automatically by a read frame to the same address, issued after GAP.
  - No rsp_valid pulse is issued after the write frame.
  - rsp_valid pulses after the read-back frame, with rsp_rdata = read-back byte and rsp_err = (read-back != wdata).
  - busy stays high across both frames.
  - Reads behave as in the base block, with rsp_err=0.
- Undefined: rsp_err is tied 0 and the verify logic is absent.

Test Plan:
- Reset mid-SHIFT (CLK_DIV=4): reset_n low at bit 5 -> cs=1 and sck=0 in the same cycle. After release, req_ready=1 and rsp_valid never pulses.
- Write addr 0x2A, data 0xC5: slave-side samples at sck rising edges = 0101010 0 11000101, exactly 16 rising edges, cs low for 136 cycles. One rsp_valid pulse; rsp_rdata unchanged.
- Read addr 0x05, miso model returns 0x9E: frame header bits 0000101 1, then rsp_valid pulse with rsp_rdata=0x9E.
- Back-to-back writes with req_valid held high: second accept on the first IDLE cycle. cs high gap = 8 cycles (GAP_HALVES=2, CLK_DIV=4); first frame unaffected.
- req_valid and a new addr presented mid-frame: req_ready=0, no accept, in-flight frame's address bits unchanged.
- VERIFY_EN build, write 0x11 to addr 0x03, model returns 0x10: two frames, single rsp_valid after the second, rsp_rdata=0x10, rsp_err=1.
